// File: rtl/cdb_pkg.sv
// Shared Common Data Bus definitions: sizing constants and the packets
// exchanged between the FU array, the CDB and the ROB/RS wakeup logic.
package cdb_pkg;

    localparam int NUM_FU    = 5;
    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 3;
    localparam int FU_IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [NUM_FU-1:0]                dones;
        logic [NUM_FU-1:0][XLEN-1:0]      v;
        logic [NUM_FU-1:0][ROB_TAG_W-1:0] rob_tags;
    } FU_CDB_PACKET;

    typedef struct packed {
        logic [NUM_FU-1:0] ack;
    } CDB_FU_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      v;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_priority_sel.sv
// Highest-index-first one-hot selector: grants the topmost asserted request
// and reports its index plus whether any request was present.
module cdb_priority_sel #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so a later (higher) request overrides any earlier one.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cdb.sv
// Common Data Bus: picks one finished FU per cycle, acks it combinationally
// and registers its tag/value as next cycle's broadcast.
module cdb
    import cdb_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  FU_CDB_PACKET fu_cdb_packet,
    output CDB_FU_PACKET cdb_fu_packet,
    output CDB_PACKET    cdb_packet
);

    logic [NUM_FU-1:0]   grant;
    logic [FU_IDX_W-1:0] win_idx;
    logic                any_done;
    CDB_PACKET           cdb_packet_d;
    CDB_PACKET           cdb_packet_q;

    cdb_priority_sel #(
        .N     (NUM_FU),
        .IDX_W (FU_IDX_W)
    ) u_sel (
        .req   (fu_cdb_packet.dones),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_done)
    );

    // An FU must never see ack during reset or a flush, or it would drop a result nobody captured.
    always_comb begin
        cdb_fu_packet.ack = '0;
        if (reset && !clear) begin
            cdb_fu_packet.ack = grant;
        end
    end

    always_comb begin
        cdb_packet_d = '0;
        if (!clear && any_done) begin
            cdb_packet_d.valid   = 1'b1;
            cdb_packet_d.rob_tag = fu_cdb_packet.rob_tags[win_idx];
            cdb_packet_d.v       = fu_cdb_packet.v[win_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_packet_q <= '0;
        end else begin
            cdb_packet_q <= cdb_packet_d;
        end
    end

    assign cdb_packet = cdb_packet_q;

endmodule

// File: tb/tb_cdb.sv
// Self-checking bench for the CDB: directed scenarios then randomized traffic
// compared against a simple "highest done wins" reference model.
module tb_cdb;
    import cdb_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear;
    FU_CDB_PACKET fu_in;
    CDB_FU_PACKET fu_ack;
    CDB_PACKET    cdb_out;

    int        checks = 0;
    int        errors = 0;
    CDB_PACKET exp_pkt;

    cdb dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .fu_cdb_packet (fu_in),
        .cdb_fu_packet (fu_ack),
        .cdb_packet    (cdb_out)
    );

    always #5 clock = ~clock;

    function automatic logic [NUM_FU-1:0] model_ack(logic [NUM_FU-1:0] d, logic clr);
        logic [NUM_FU-1:0] a;
        a = '0;
        if (clr) return a;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (d[i]) begin
                a[i] = 1'b1;
                return a;
            end
        end
        return a;
    endfunction

    function automatic CDB_PACKET model_pkt(FU_CDB_PACKET p, logic clr);
        CDB_PACKET r;
        r = '0;
        if (clr) return r;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (p.dones[i]) begin
                r.valid   = 1'b1;
                r.rob_tag = p.rob_tags[i];
                r.v       = p.v[i];
                return r;
            end
        end
        return r;
    endfunction

    // FU i carries value (i+1)*10 and tag i+1, matching the directed scenarios.
    function automatic FU_CDB_PACKET directed_pkt(logic [NUM_FU-1:0] d);
        FU_CDB_PACKET p;
        p.dones = d;
        for (int i = 0; i < NUM_FU; i++) begin
            p.v[i]        = XLEN'((i + 1) * 10);
            p.rob_tags[i] = ROB_TAG_W'(i + 1);
        end
        return p;
    endfunction

    task automatic check_ack(string tag, logic [NUM_FU-1:0] expected);
        checks++;
        assert (fu_ack.ack === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s ack observed=%b expected=%b", tag, fu_ack.ack, expected);
        end
    endtask

    task automatic check_output(string tag, CDB_PACKET expected);
        checks++;
        assert (cdb_out === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s cdb observed valid=%b tag=%0d v=%0d expected valid=%b tag=%0d v=%0d",
                   tag, cdb_out.valid, cdb_out.rob_tag, cdb_out.v,
                   expected.valid, expected.rob_tag, expected.v);
        end
    endtask

    // Drive one cycle of FU traffic, check the ack before the edge and the broadcast after it.
    task automatic apply_stimulus(string tag, FU_CDB_PACKET p, logic clr);
        @(negedge clock);
        fu_in = p;
        clear = clr;
        #1;
        check_ack(tag, model_ack(p.dones, clr));
        exp_pkt = model_pkt(p, clr);
        @(posedge clock);
        #1;
        check_output(tag, exp_pkt);
    endtask

    initial begin
        FU_CDB_PACKET rp;
        logic         rclr;

        reset = 1'b0;
        clear = 1'b0;
        fu_in = directed_pkt(5'b11111);

        @(negedge clock);
        #1;
        check_ack("reset_ack", '0);
        check_output("reset_pkt", '0);

        @(negedge clock);
        reset = 1'b1;
        fu_in = directed_pkt('0);
        apply_stimulus("idle_after_reset", directed_pkt('0), 1'b0);

        apply_stimulus("multi_req", directed_pkt(5'b01100), 1'b0);
        apply_stimulus("multi_req_hold", directed_pkt(5'b01100), 1'b0);
        apply_stimulus("handoff", directed_pkt(5'b00100), 1'b0);
        apply_stimulus("handoff_idle", directed_pkt(5'b00000), 1'b0);

        apply_stimulus("single_low", directed_pkt(5'b00001), 1'b0);
        apply_stimulus("all_high", directed_pkt(5'b11111), 1'b0);

        apply_stimulus("clear", directed_pkt(5'b00110), 1'b1);
        apply_stimulus("after_clear", directed_pkt(5'b00110), 1'b0);

        apply_stimulus("pre_async_reset", directed_pkt(5'b10000), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset_pkt", '0);
        check_ack("async_reset_ack", '0);
        @(negedge clock);
        reset = 1'b1;
        apply_stimulus("post_async_reset", directed_pkt(5'b01010), 1'b0);

        for (int n = 0; n < 300; n++) begin
            rp.dones = NUM_FU'($urandom_range(0, (1 << NUM_FU) - 1));
            for (int i = 0; i < NUM_FU; i++) begin
                rp.v[i]        = $urandom;
                rp.rob_tags[i] = ROB_TAG_W'($urandom_range(0, (1 << ROB_TAG_W) - 1));
            end
            rclr = ($urandom_range(0, 9) == 0);
            apply_stimulus("random", rp, rclr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
